// File: rtl/ps2_scan_receiver_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } frame_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_scan_receiver_if.sv
// Key-event handshake plus raw-byte / status observation bundle.
interface ps2_evt_if;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [7:0] EVT_CODE;
  logic       EVT_EXT;
  logic       EVT_REL;
  logic       RAW_VALID;
  logic [7:0] RAW_BYTE;
  logic [7:0] ERR_CNT;
  logic       OVERFLOW;

  modport master (
    output EVT_VALID, EVT_CODE, EVT_EXT, EVT_REL,
    output RAW_VALID, RAW_BYTE, ERR_CNT, OVERFLOW,
    input  EVT_READY
  );

  modport slave (
    input  EVT_VALID, EVT_CODE, EVT_EXT, EVT_REL,
    input  RAW_VALID, RAW_BYTE, ERR_CNT, OVERFLOW,
    output EVT_READY
  );
endinterface

// File: rtl/ps2_scan_receiver_evt_fifo.sv
// Synchronous event FIFO; head is shown combinationally, pushes into a full
// FIFO are ignored unless a pop frees a slot in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     CLK,
  input  logic     RST_N,
  input  logic     i_push,
  input  ps2_evt_t i_data,
  input  logic     i_ready,
  output logic     o_valid,
  output ps2_evt_t o_data,
  output logic     o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  ps2_evt_t    r_mem [DEPTH];
  logic        w_pop;
  logic        w_wr_en;

  assign o_valid = (r_wr_ptr != r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop   = o_valid && i_ready;
  assign w_wr_en = i_push && (!o_full || w_pop);

  // pointer update; extra MSB distinguishes full from empty
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // storage write, no reset needed for payload
  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 device-to-host receiver: sync, tick-rate glitch filter, 11-bit
// deframer, E0/F0 prefix folding and a key-event FIFO.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | waiting for a start bit (falling edge with data 0)
// ST_SHIFT | collecting bits 2..11, abandoned silently on timeout
// ST_CHECK | one cycle: validate start/stop/parity, act on byte
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int CLK_DIV       = 250,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  ps2_evt_if.master  evt
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  logic             r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic [DIV_W-1:0] r_div;
  logic             r_fclk;
  logic [3:0]       r_fcnt;
  frame_state_t     r_state, w_state_nxt;
  logic [10:0]      r_shreg;
  logic [3:0]       r_bit_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_ext, r_rel, r_push, r_raw_valid, r_overflow;
  logic [7:0]       r_raw_byte, r_err_cnt;
  ps2_evt_t         r_push_data, w_head;
  logic             w_tick, w_fall, w_to_hit, w_good, w_full, w_drop;
  logic [7:0]       w_byte;

  assign w_tick   = (r_div == '0);
  assign w_fall   = w_tick && r_fclk && !r_clk_sync &&
                    (r_fcnt == 4'(FILTER_LEN - 1));
  assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));
  assign w_byte   = r_shreg[8:1];
  assign w_good   = !r_shreg[0] && r_shreg[10] && (^r_shreg[9:1]);
  assign w_drop   = r_push && w_full && !(evt.EVT_VALID && evt.EVT_READY);

  // two-flop synchronisers, idle-high lines
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_clk_meta <= 1'b1; r_clk_sync <= 1'b1;
      r_dat_meta <= 1'b1; r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= PS2_CLK;  r_clk_sync <= r_clk_meta;
      r_dat_meta <= PS2_DATA; r_dat_sync <= r_dat_meta;
    end
  end

  // sample-tick down-counter and PS2 clock glitch filter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div  <= '0;
      r_fclk <= 1'b1;
      r_fcnt <= '0;
    end else begin
      r_div <= w_tick ? DIV_W'(CLK_DIV - 1) : r_div - DIV_W'(1);
      if (w_tick) begin
        if (r_clk_sync == r_fclk) begin
          r_fcnt <= '0;
        end else if (r_fcnt == 4'(FILTER_LEN - 1)) begin
          r_fclk <= ~r_fclk;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 4'd1;
        end
      end
    end
  end

  // frame state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // frame next-state; a falling edge beats a coincident timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_fall && !r_dat_sync) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd10) w_state_nxt = ST_CHECK;
        end else if (w_tick && w_to_hit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CHECK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // shift register, bit counter and inter-edge timeout counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else if (r_state == ST_IDLE) begin
      r_to_cnt <= '0;
      if (w_fall && !r_dat_sync) begin
        r_shreg   <= {r_dat_sync, r_shreg[10:1]};
        r_bit_cnt <= 4'd1;
      end
    end else if (r_state == ST_SHIFT) begin
      if (w_fall) begin
        r_shreg   <= {r_dat_sync, r_shreg[10:1]};
        r_bit_cnt <= r_bit_cnt + 4'd1;
        r_to_cnt  <= '0;
      end else if (w_tick) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  // byte handling: raw strobe, prefix folding, error count, overflow
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_raw_valid <= 1'b0;
      r_raw_byte  <= '0;
      r_err_cnt   <= '0;
      r_ext       <= 1'b0;
      r_rel       <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_raw_valid <= 1'b0;
      r_push      <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      if (r_state == ST_CHECK) begin
        if (w_good) begin
          r_raw_valid <= 1'b1;
          r_raw_byte  <= w_byte;
          if (w_byte == PS2_EXT) begin
            r_ext <= 1'b1;
          end else if (w_byte == PS2_REL) begin
            r_rel <= 1'b1;
          end else begin
            r_push      <= 1'b1;
            r_push_data <= '{code: w_byte, ext: r_ext, rel: r_rel};
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
          end
        end else begin
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          r_ext <= 1'b0;
          r_rel <= 1'b0;
        end
      end
    end
  end

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_ready (evt.EVT_READY),
    .o_valid (evt.EVT_VALID),
    .o_data  (w_head),
    .o_full  (w_full)
  );

  assign evt.EVT_CODE  = w_head.code;
  assign evt.EVT_EXT   = w_head.ext;
  assign evt.EVT_REL   = w_head.rel;
  assign evt.RAW_VALID = r_raw_valid;
  assign evt.RAW_BYTE  = r_raw_byte;
  assign evt.ERR_CNT   = r_err_cnt;
  assign evt.OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver (CLK_DIV=4, FILTER_LEN=2).
module tb_ps2_scan_receiver;

  localparam int TO_TICKS = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] raw_q[$];
  logic [9:0] evt_q[$];

  ps2_evt_if evt_if ();

  ps2_scan_receiver #(
    .CLK_DIV(4), .FILTER_LEN(2), .TIMEOUT_TICKS(TO_TICKS), .FIFO_DEPTH(8)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .evt(evt_if)
  );

  always #5 clk = ~clk;

  // record raw bytes and accepted events away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_if.RAW_VALID) raw_q.push_back(evt_if.RAW_BYTE);
      if (evt_if.EVT_VALID && evt_if.EVT_READY)
        evt_q.push_back({evt_if.EVT_CODE, evt_if.EVT_EXT, evt_if.EVT_REL});
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; evt_if.EVT_READY = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    raw_q.delete(); evt_q.delete();
  endtask

  // one bit: data set while clock high, then a low half-period
  task automatic send_bit(logic b, bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_clk(8); ps2_clk = 1'b0; wait_clk(4); ps2_clk = 1'b1; wait_clk(12);
    end else begin
      wait_clk(24);
    end
    ps2_clk = 1'b0; wait_clk(24); ps2_clk = 1'b1;
  endtask

  task automatic send_frame(logic [7:0] b, bit bad_par = 0, int nbits = 11,
                            int glitch_at = -1);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], i == glitch_at);
    ps2_data = 1'b1;
    wait_clk(40);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (evt_if.EVT_VALID !== 1'b0) begin errors++; $display("FAIL rst_evt_valid got=%b want=0", evt_if.EVT_VALID); end
    checks++; if (evt_if.RAW_VALID !== 1'b0) begin errors++; $display("FAIL rst_raw_valid got=%b want=0", evt_if.RAW_VALID); end
    checks++; if (evt_if.RAW_BYTE !== 8'h00) begin errors++; $display("FAIL rst_raw_byte got=%h want=00", evt_if.RAW_BYTE); end
    checks++; if (evt_if.ERR_CNT !== 8'h00) begin errors++; $display("FAIL rst_err_cnt got=%0d want=0", evt_if.ERR_CNT); end
    checks++; if (evt_if.OVERFLOW !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b want=0", evt_if.OVERFLOW); end
  endtask

  task automatic test_single();
    do_reset();
    send_frame(8'h1C);
    checks++; if (evt_q.size() !== 1) begin errors++; $display("FAIL single_evt_count got=%0d want=1", evt_q.size()); end
    else begin
      checks++; if (evt_q[0] !== {8'h1C, 2'b00}) begin errors++; $display("FAIL single_evt got=%h want=%h", evt_q[0], {8'h1C, 2'b00}); end
    end
    checks++; if (raw_q.size() !== 1) begin errors++; $display("FAIL single_raw_count got=%0d want=1", raw_q.size()); end
    checks++; if (evt_if.ERR_CNT !== 8'h00) begin errors++; $display("FAIL single_err got=%0d want=0", evt_if.ERR_CNT); end
    checks++; if (evt_if.RAW_BYTE !== 8'h1C) begin errors++; $display("FAIL single_raw_byte got=%h want=1C", evt_if.RAW_BYTE); end
  endtask

  task automatic test_prefix();
    logic [7:0] exp_raw [3];
    exp_raw = '{8'hE0, 8'hF0, 8'h75};
    do_reset();
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    checks++; if (evt_q.size() !== 1) begin errors++; $display("FAIL prefix_evt_count got=%0d want=1", evt_q.size()); end
    else begin
      checks++; if (evt_q[0] !== {8'h75, 2'b11}) begin errors++; $display("FAIL prefix_evt got=%h want=%h", evt_q[0], {8'h75, 2'b11}); end
    end
    checks++; if (raw_q.size() !== 3) begin errors++; $display("FAIL prefix_raw_count got=%0d want=3", raw_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (raw_q[i] !== exp_raw[i]) begin errors++; $display("FAIL prefix_raw[%0d] got=%h want=%h", i, raw_q[i], exp_raw[i]); end
      end
    end
  endtask

  task automatic test_parity_err();
    do_reset();
    send_frame(8'h1C, 1);
    send_frame(8'h1C);
    checks++; if (evt_if.ERR_CNT !== 8'd1) begin errors++; $display("FAIL parity_err_cnt got=%0d want=1", evt_if.ERR_CNT); end
    checks++; if (evt_q.size() !== 1) begin errors++; $display("FAIL parity_evt_count got=%0d want=1", evt_q.size()); end
    else begin
      checks++; if (evt_q[0] !== {8'h1C, 2'b00}) begin errors++; $display("FAIL parity_evt got=%h want=%h", evt_q[0], {8'h1C, 2'b00}); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_frame(8'h55, 0, 5);
    wait_clk((TO_TICKS + 1) * 4 + 20);
    send_frame(8'h72);
    checks++; if (evt_q.size() !== 1) begin errors++; $display("FAIL timeout_evt_count got=%0d want=1", evt_q.size()); end
    else begin
      checks++; if (evt_q[0] !== {8'h72, 2'b00}) begin errors++; $display("FAIL timeout_evt got=%h want=%h", evt_q[0], {8'h72, 2'b00}); end
    end
    checks++; if (evt_if.ERR_CNT !== 8'h00) begin errors++; $display("FAIL timeout_err got=%0d want=0", evt_if.ERR_CNT); end
  endtask

  task automatic test_overflow();
    do_reset();
    evt_if.EVT_READY = 1'b0;
    for (int i = 1; i <= 9; i++) send_frame(8'(i));
    checks++; if (evt_if.OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b want=1", evt_if.OVERFLOW); end
    checks++; if (evt_if.EVT_VALID !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b want=1", evt_if.EVT_VALID); end
    checks++; if (evt_if.EVT_CODE !== 8'h01) begin errors++; $display("FAIL ovf_head_stall got=%h want=01", evt_if.EVT_CODE); end
    evt_if.EVT_READY = 1'b1;
    wait_clk(20);
    checks++; if (evt_q.size() !== 8) begin errors++; $display("FAIL ovf_drain_count got=%0d want=8", evt_q.size()); end
    for (int i = 0; i < evt_q.size(); i++) begin
      checks++; if (evt_q[i] !== {8'(i + 1), 2'b00}) begin errors++; $display("FAIL ovf_drain[%0d] got=%h want=%h", i, evt_q[i], {8'(i + 1), 2'b00}); end
    end
    checks++; if (evt_if.EVT_VALID !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%b want=0", evt_if.EVT_VALID); end
  endtask

  task automatic test_glitch();
    do_reset();
    ps2_data = 1'b0; ps2_clk = 1'b0; wait_clk(4); ps2_clk = 1'b1;
    ps2_data = 1'b1; wait_clk(40);
    send_frame(8'h5A, 0, 11, 4);
    checks++; if (evt_q.size() !== 1) begin errors++; $display("FAIL glitch_evt_count got=%0d want=1", evt_q.size()); end
    else begin
      checks++; if (evt_q[0] !== {8'h5A, 2'b00}) begin errors++; $display("FAIL glitch_evt got=%h want=%h", evt_q[0], {8'h5A, 2'b00}); end
    end
    checks++; if (evt_if.ERR_CNT !== 8'h00) begin errors++; $display("FAIL glitch_err got=%0d want=0", evt_if.ERR_CNT); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    evt_if.EVT_READY = 1'b0;
    send_frame(8'h1C);
    send_frame(8'h00, 1);
    send_frame(8'hE0);
    checks++; if (evt_if.ERR_CNT !== 8'd1) begin errors++; $display("FAIL mid_pre_err got=%0d want=1", evt_if.ERR_CNT); end
    checks++; if (evt_if.EVT_VALID !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b want=1", evt_if.EVT_VALID); end
    send_frame(8'h33, 0, 4);
    rst_n = 1'b0;
    wait_clk(2);
    checks++; if (evt_if.EVT_VALID !== 1'b0) begin errors++; $display("FAIL mid_evt_valid got=%b want=0", evt_if.EVT_VALID); end
    checks++; if (evt_if.RAW_BYTE !== 8'h00) begin errors++; $display("FAIL mid_raw_byte got=%h want=00", evt_if.RAW_BYTE); end
    checks++; if (evt_if.ERR_CNT !== 8'h00) begin errors++; $display("FAIL mid_err got=%0d want=0", evt_if.ERR_CNT); end
    checks++; if (evt_if.RAW_VALID !== 1'b0) begin errors++; $display("FAIL mid_raw_valid got=%b want=0", evt_if.RAW_VALID); end
    checks++; if (evt_if.OVERFLOW !== 1'b0) begin errors++; $display("FAIL mid_overflow got=%b want=0", evt_if.OVERFLOW); end
    rst_n = 1'b1; evt_if.EVT_READY = 1'b1;
    wait_clk(5);
    raw_q.delete(); evt_q.delete();
    send_frame(8'h1C);
    checks++; if (evt_q.size() !== 1) begin errors++; $display("FAIL mid_post_count got=%0d want=1", evt_q.size()); end
    else begin
      checks++; if (evt_q[0] !== {8'h1C, 2'b00}) begin errors++; $display("FAIL mid_post_evt got=%h want=%h", evt_q[0], {8'h1C, 2'b00}); end
    end
  endtask

  initial begin
    evt_if.EVT_READY = 1'b1;
    test_reset();
    test_single();
    test_prefix();
    test_parity_err();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

Parametrised PS/2 device-to-host receiver for the Videopac keyboard path. It samples the raw PS/2 clock and data lines at a divided tick rate and glitch-filters the clock. It deframes 11-bit packets with start, stop and parity checking, folds the E0 (extended) and F0 (release) prefixes into single key events, and queues those events in a FIFO behind a valid/ready handshake. It sits between the board PS/2 pins and the keyboard-matrix emulation logic.

## Interface
Parameters:
- CLK_DIV, 250: CLK cycles per sample tick (≥2).
- FILTER_LEN, 4: consecutive equal ticks required before the filtered PS2_CLK changes (1..15).
- TIMEOUT_TICKS, 4000: idle ticks inside a frame before it is abandoned.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, ≥2.

Ports:
- CLK, in, 1: system clock; the only clock.
- RST_N, in, 1: reset, asynchronous, active-low.
- PS2_CLK, in, 1: raw keyboard clock, asynchronous.
- PS2_DATA, in, 1: raw keyboard data, asynchronous.
- EVT_VALID, out, 1: FIFO head holds an event.
- EVT_READY, in, 1: consumer accepts the head when EVT_VALID is high.
- EVT_CODE, out, 8: scan code of the head event.
- EVT_EXT, out, 1: head event was preceded by E0.
- EVT_REL, out, 1: head event was preceded by F0 (key release).
- RAW_VALID, out, 1: one-cycle pulse for every good byte, prefixes included.
- RAW_BYTE, out, 8: that byte; held until the next good byte.
- ERR_CNT, out, 8: count of bad frames, saturates at 255.
- OVERFLOW, out, 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Both PS/2 inputs pass through a 2-flop synchroniser on CLK. A free-running divider raises TICK for one cycle every CLK_DIV cycles.
- Filter, evaluated on TICK: a counter runs while the synchronised clock differs from the filtered clock. When the counter reaches FILTER_LEN, the filtered clock flips and the counter clears. The counter also clears on any tick where the two clocks are equal.
- A falling edge of the filtered clock samples PS2_DATA (synchronised) on the same tick.
- Frame FSM states are IDLE, SHIFT and CHECK.
  - IDLE → SHIFT on the first falling edge. That bit is the start bit and must be 0; a start bit of 1 is discarded and the FSM stays in IDLE without counting an error.
  - SHIFT: bits are taken LSB first into an 11-bit shift register. A 4-bit counter tracks bits. After the 11th bit the FSM goes to CHECK.
  - In SHIFT, the timeout counter increments on each tick and clears on each falling edge. When it reaches TIMEOUT_TICKS, the FSM returns to IDLE silently, with no error.
  - CHECK lasts one CLK cycle. The frame is good when start = 0, stop = 1, and the XOR of the 8 data bits and the parity bit is 1 (odd parity). The FSM then returns to IDLE.
- Good byte handling:
  - RAW_VALID pulses.
  - E0 sets the ext flag. F0 sets the rel flag.
  - Any other byte pushes {code, ext, rel} into the FIFO and clears both flags.
- Bad frame handling: ERR_CNT increments (saturating at 255) and both prefix flags clear.
- FIFO:
  - The head is visible combinationally on EVT_*.
  - A pop occurs when EVT_VALID && EVT_READY.
  - A push into a full FIFO is dropped and sets OVERFLOW. A push and a pop in the same cycle on a full FIFO both succeed.
  - Push and pop on an empty FIFO are impossible in the same cycle, because EVT_VALID is low.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Reset values: EVT_VALID 0, RAW_VALID 0, RAW_BYTE 0, ERR_CNT 0, OVERFLOW 0. In addition:
  - The FIFO is emptied.
  - The FSM returns to IDLE.
  - The filtered clock is set to 1.
  - The prefix flags are cleared.
  - The divider is set to 0.
- Reset asserted mid-frame or mid-prefix discards all partial state.

## Timing
- Falling edge detection: FILTER_LEN ticks after a stable low appears at the synchroniser output.
- The 11th sample occurs on tick T. CHECK is the cycle after T. RAW_VALID and the FIFO write happen on the next cycle, T+2. EVT_VALID is high at T+3 when the FIFO was empty.
- EVT_* remain stable while EVT_VALID && !EVT_READY.
- Throughput is one event per PS/2 frame; the FIFO only buffers consumer back-pressure.
- A timeout and a falling edge on the same tick: the edge wins.

## Structure
- Package ps2_pkg holds:
  - the prefix constants PS2_EXT = 8'hE0 and PS2_REL = 8'hF0;
  - the frame FSM state enum;
  - the event struct {code[7:0], ext, rel}.
- One sub-module, ps2_evt_fifo: a parametrised synchronous FIFO with valid/ready output, full flag and drop-on-full.

## Test plan
- CLK_DIV=4, FILTER_LEN=2. Send frame 0x1C (parity 0) → one event: CODE=1C, EXT=0, REL=0. RAW_VALID pulses once. ERR_CNT=0.
- Send E0, F0, 75 → exactly one event: CODE=75, EXT=1, REL=1. RAW_VALID pulses 3 times with RAW_BYTE E0, F0, 75.
- Send 0x1C with parity flipped, then 0x1C → ERR_CNT=1 and exactly one event (1C).
- Send 5 bits, go silent for TIMEOUT_TICKS+1 ticks, then send 0x72 → one event: CODE=72. ERR_CNT=0.
- With EVT_READY=0 and FIFO_DEPTH=8, send 9 codes 0x01..0x09 → 8 events 01..08 retained and OVERFLOW=1. Then raise EVT_READY → events 01..08 pop in order and EVT_VALID drops.
- Inject a PS2_CLK low glitch 1 tick long in IDLE and mid-frame → no bit captured, and the frame still decodes correctly. Assert RST_N mid-frame → all outputs return to their reset values.
